// File: rtl/brownout_ctrl.sv
// Brownout detector controller: programs the detector, waits out its settling
// time, then tracks the synchronized supply-good flag and counts brownout events.
module brownout_ctrl #(
  parameter int SETTLE_CYC = 64
) (
  input  logic       sys_ck,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic       cfg_ena,
  input  logic [2:0] cfg_vtrip,
  input  logic [2:0] cfg_otrip,
  input  logic       cfg_short,
  input  logic       bo_good,
  input  logic       irq_clr,
  input  logic       cnt_clr,
  output logic       ena,
  output logic [2:0] vtrip,
  output logic [2:0] otrip,
  output logic       force_short_oneshot,
  output logic       ready,
  output logic       bo_active,
  output logic       irq,
  output logic [7:0] event_cnt
);

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    SETTLE  = 2'd1,
    ARMED   = 2'd2,
    TRIPPED = 2'd3
  } state_t;

  localparam logic [11:0] SETTLE_LOAD = 12'(SETTLE_CYC - 1);

  state_t      state;
  logic [11:0] settle_cnt;
  logic        sync_1;
  logic        bo_good_s;
  logic        trip_event;

  // Synchronizer flops power up as "supply good" so reset never looks like a brownout.
  always_ff @(posedge sys_ck or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b1;
      bo_good_s <= 1'b1;
    end else begin
      sync_1    <= bo_good;
      bo_good_s <= sync_1;
    end
  end

  // A configuration write on the same edge pre-empts a trip.
  assign trip_event = (state == ARMED) && !bo_good_s && !cfg_wr;

  always_ff @(posedge sys_ck or posedge rst) begin
    if (rst) begin
      state               <= OFF;
      settle_cnt          <= '0;
      ena                 <= 1'b0;
      vtrip               <= '0;
      otrip               <= '0;
      force_short_oneshot <= 1'b0;
      ready               <= 1'b0;
      bo_active           <= 1'b0;
      irq                 <= 1'b0;
      event_cnt           <= '0;
    end else begin
      if (cfg_wr) begin
        vtrip               <= cfg_vtrip;
        otrip               <= cfg_otrip;
        force_short_oneshot <= cfg_short;
        ready               <= 1'b0;
        bo_active           <= 1'b0;
        ena                 <= cfg_ena;
        if (cfg_ena) begin
          state      <= SETTLE;
          settle_cnt <= SETTLE_LOAD;
        end else begin
          state      <= OFF;
        end
      end else begin
        case (state)
          SETTLE: begin
            if (settle_cnt == '0) begin
              state <= ARMED;
              ready <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt - 12'd1;
            end
          end
          ARMED: begin
            if (!bo_good_s) begin
              state     <= TRIPPED;
              ready     <= 1'b0;
              bo_active <= 1'b1;
            end
          end
          TRIPPED: begin
            if (bo_good_s) begin
              state     <= ARMED;
              ready     <= 1'b1;
              bo_active <= 1'b0;
            end
          end
          default: begin
            ready     <= 1'b0;
            bo_active <= 1'b0;
            ena       <= 1'b0;
          end
        endcase
      end

      // A new event outranks a simultaneous clear, for both irq and counter.
      if (trip_event) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end

      if (cnt_clr) begin
        event_cnt <= trip_event ? 8'd1 : 8'd0;
      end else if (trip_event && event_cnt != 8'hFF) begin
        event_cnt <= event_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_brownout_ctrl.sv
// Self-checking bench for brownout_ctrl: cycle-level behavioural model plus
// directed scenarios with literal expectations.
module tb_brownout_ctrl;

  localparam int SETTLE_CYC = 64;

  logic       sys_ck = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_wr = 1'b0;
  logic       cfg_ena = 1'b0;
  logic [2:0] cfg_vtrip = 3'd0;
  logic [2:0] cfg_otrip = 3'd0;
  logic       cfg_short = 1'b0;
  logic       bo_good = 1'b1;
  logic       irq_clr = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       ena;
  logic [2:0] vtrip;
  logic [2:0] otrip;
  logic       force_short_oneshot;
  logic       ready;
  logic       bo_active;
  logic       irq;
  logic [7:0] event_cnt;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  brownout_ctrl #(.SETTLE_CYC(SETTLE_CYC)) dut (
    .sys_ck(sys_ck), .rst(rst), .cfg_wr(cfg_wr), .cfg_ena(cfg_ena),
    .cfg_vtrip(cfg_vtrip), .cfg_otrip(cfg_otrip), .cfg_short(cfg_short),
    .bo_good(bo_good), .irq_clr(irq_clr), .cnt_clr(cnt_clr),
    .ena(ena), .vtrip(vtrip), .otrip(otrip),
    .force_short_oneshot(force_short_oneshot), .ready(ready),
    .bo_active(bo_active), .irq(irq), .event_cnt(event_cnt)
  );

  always #5 sys_ck = ~sys_ck;

  // Model: time-based view of the controller. It remembers when the detector
  // becomes usable (cycle number) and what bo_good looked like two edges ago.
  int       cyc = 0;
  int       ready_at = 0;
  bit       m_enabled = 1'b0;
  bit       m_tripped = 1'b0;
  bit [2:0] m_vtrip = 3'd0;
  bit [2:0] m_otrip = 3'd0;
  bit       m_short = 1'b0;
  bit       m_irq = 1'b0;
  int       m_cnt = 0;
  bit       seen_d1 = 1'b1;
  bit       seen_d2 = 1'b1;

  always @(posedge sys_ck or posedge rst) begin
    bit seen;
    bit ev;
    if (rst) begin
      m_enabled = 1'b0; m_tripped = 1'b0;
      m_vtrip = 3'd0; m_otrip = 3'd0; m_short = 1'b0;
      m_irq = 1'b0; m_cnt = 0;
      seen_d1 = 1'b1; seen_d2 = 1'b1;
    end else begin
      cyc = cyc + 1;
      seen = seen_d2;
      seen_d2 = seen_d1;
      seen_d1 = bo_good;
      ev = 1'b0;
      if (cfg_wr) begin
        m_vtrip = cfg_vtrip; m_otrip = cfg_otrip; m_short = cfg_short;
        m_enabled = cfg_ena;
        m_tripped = 1'b0;
        ready_at = cyc + SETTLE_CYC;
      end else if (m_enabled && cyc > ready_at) begin
        if (!m_tripped && !seen) begin
          m_tripped = 1'b1;
          ev = 1'b1;
        end else if (m_tripped && seen) begin
          m_tripped = 1'b0;
        end
      end
      if (ev) m_irq = 1'b1;
      else if (irq_clr) m_irq = 1'b0;
      if (cnt_clr) m_cnt = ev ? 1 : 0;
      else if (ev && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge sys_ck) begin
    bit settled;
    if (started && !rst) begin
      settled = m_enabled && (cyc >= ready_at);
      checkOutput("model.ena", int'(ena), int'(m_enabled));
      checkOutput("model.vtrip", int'(vtrip), int'(m_vtrip));
      checkOutput("model.otrip", int'(otrip), int'(m_otrip));
      checkOutput("model.short", int'(force_short_oneshot), int'(m_short));
      checkOutput("model.ready", int'(ready), int'(settled && !m_tripped));
      checkOutput("model.bo_active", int'(bo_active), int'(settled && m_tripped));
      checkOutput("model.irq", int'(irq), int'(m_irq));
      checkOutput("model.event_cnt", int'(event_cnt), m_cnt);
    end
  end

  task automatic step();
    @(posedge sys_ck);
    #3;
    cfg_wr = 1'b0; irq_clr = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic applyStimulus(input bit wr, input bit en, input bit [2:0] vt,
                               input bit [2:0] ot, input bit sh,
                               input bit iclr, input bit cclr);
    cfg_wr = wr; cfg_ena = en; cfg_vtrip = vt; cfg_otrip = ot; cfg_short = sh;
    irq_clr = iclr; cnt_clr = cclr;
    step();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".ena"}, int'(ena), 0);
    checkOutput({tag, ".vtrip"}, int'(vtrip), 0);
    checkOutput({tag, ".otrip"}, int'(otrip), 0);
    checkOutput({tag, ".short"}, int'(force_short_oneshot), 0);
    checkOutput({tag, ".ready"}, int'(ready), 0);
    checkOutput({tag, ".bo_active"}, int'(bo_active), 0);
    checkOutput({tag, ".irq"}, int'(irq), 0);
    checkOutput({tag, ".event_cnt"}, int'(event_cnt), 0);
  endtask

  initial begin
    #1;
    checkReset("por");
    #20 rst = 1'b0;
    @(posedge sys_ck); #3;
    started = 1'b1;

    // Enable with bo_good low during the whole settle window.
    bo_good = 1'b0;
    applyStimulus(1, 1, 3'd5, 3'd2, 0, 0, 0);
    checkOutput("cfg.ena", int'(ena), 1);
    checkOutput("cfg.vtrip", int'(vtrip), 5);
    checkOutput("cfg.otrip", int'(otrip), 2);
    checkOutput("cfg.ready", int'(ready), 0);
    repeat (62) step();
    checkOutput("settle62.ready", int'(ready), 0);
    bo_good = 1'b1;
    step();
    checkOutput("settle63.ready", int'(ready), 0);
    step();
    checkOutput("settle64.ready", int'(ready), 1);
    checkOutput("settle64.irq", int'(irq), 0);
    checkOutput("settle64.cnt", int'(event_cnt), 0);

    // Ten-cycle brownout: two-edge synchronizer latency each way.
    bo_good = 1'b0;
    step();
    step();
    checkOutput("trip_n1.irq", int'(irq), 0);
    step();
    checkOutput("trip_n2.irq", int'(irq), 1);
    checkOutput("trip_n2.cnt", int'(event_cnt), 1);
    checkOutput("trip_n2.bo_active", int'(bo_active), 1);
    checkOutput("trip_n2.ready", int'(ready), 0);
    repeat (7) step();
    bo_good = 1'b1;
    step();
    step();
    checkOutput("rise_m1.bo_active", int'(bo_active), 1);
    step();
    checkOutput("rise_m2.bo_active", int'(bo_active), 0);
    checkOutput("rise_m2.ready", int'(ready), 1);
    checkOutput("rise_m2.cnt", int'(event_cnt), 1);

    // irq_clr coinciding with a new event keeps irq set; alone it clears.
    bo_good = 1'b0;
    step();
    step();
    applyStimulus(0, 1, 3'd5, 3'd2, 0, 1, 0);
    checkOutput("iclr_ev.irq", int'(irq), 1);
    checkOutput("iclr_ev.cnt", int'(event_cnt), 2);
    bo_good = 1'b1;
    repeat (3) step();
    applyStimulus(0, 1, 3'd5, 3'd2, 0, 1, 0);
    checkOutput("iclr.irq", int'(irq), 0);

    // Saturation, then clear coinciding with an event.
    for (int p = 0; p < 260; p++) begin
      bo_good = 1'b0;
      repeat (3) step();
      bo_good = 1'b1;
      repeat (3) step();
    end
    checkOutput("sat.cnt", int'(event_cnt), 255);
    bo_good = 1'b0;
    step();
    step();
    applyStimulus(0, 1, 3'd5, 3'd2, 0, 0, 1);
    checkOutput("cclr_ev.cnt", int'(event_cnt), 1);
    bo_good = 1'b1;
    repeat (3) step();

    // Reconfigure on the very edge a trip would happen.
    bo_good = 1'b0;
    step();
    step();
    applyStimulus(1, 1, 3'd3, 3'd2, 1, 0, 0);
    checkOutput("race.ready", int'(ready), 0);
    checkOutput("race.bo_active", int'(bo_active), 0);
    checkOutput("race.vtrip", int'(vtrip), 3);
    checkOutput("race.short", int'(force_short_oneshot), 1);
    checkOutput("race.cnt", int'(event_cnt), 1);
    repeat (63) step();
    checkOutput("race63.ready", int'(ready), 0);
    step();
    checkOutput("race64.ready", int'(ready), 1);
    step();
    checkOutput("race65.bo_active", int'(bo_active), 1);
    checkOutput("race65.cnt", int'(event_cnt), 2);
    applyStimulus(1, 0, 3'd3, 3'd2, 1, 0, 0);
    checkOutput("off.ena", int'(ena), 0);
    checkOutput("off.bo_active", int'(bo_active), 0);
    checkOutput("off.ready", int'(ready), 0);
    checkOutput("off.cnt", int'(event_cnt), 2);
    checkOutput("off.irq", int'(irq), 1);

    // Reset mid-settle.
    bo_good = 1'b1;
    applyStimulus(1, 1, 3'd6, 3'd4, 1, 0, 0);
    repeat (10) step();
    rst = 1'b1;
    #1;
    checkReset("rst_settle");
    @(posedge sys_ck); #3;
    rst = 1'b0;

    // First write after release is taken on the first edge; then trip.
    bo_good = 1'b0;
    applyStimulus(1, 1, 3'd1, 3'd1, 0, 0, 0);
    checkOutput("post_rst.ena", int'(ena), 1);
    checkOutput("post_rst.vtrip", int'(vtrip), 1);
    repeat (65) step();
    checkOutput("post_rst.bo_active", int'(bo_active), 1);
    checkOutput("post_rst.cnt", int'(event_cnt), 1);

    // Reset mid-tripped, then run with supply good: no spurious event.
    rst = 1'b1;
    #1;
    checkReset("rst_trip");
    bo_good = 1'b1;
    @(posedge sys_ck); #3;
    rst = 1'b0;
    applyStimulus(1, 1, 3'd2, 3'd2, 0, 0, 0);
    repeat (70) step();
    checkOutput("final.ready", int'(ready), 1);
    checkOutput("final.cnt", int'(event_cnt), 0);
    checkOutput("final.irq", int'(irq), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/brownout_ctrl.md
BROWNOUT_CTRL -- requirements
Module: brownout_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 64, sys_ck cycles during which brownout status is ignored after enable or trip change; legal range 1..4095.
REQ-002 sys_ck  in  1  sole clock; all flops on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cfg_wr  in  1  single-cycle strobe; captures cfg_ena, cfg_vtrip, cfg_otrip and cfg_short.
REQ-005 cfg_ena  in  1  requested enable of the brownout detector.
REQ-006 cfg_vtrip  in  3  requested vtrip code.
REQ-007 cfg_otrip  in  3  requested otrip code.
REQ-008 cfg_short  in  1  requested force_short_oneshot value.
REQ-009 bo_good  in  1  asynchronous supply-good output of the brownout detector; 0 = brownout or one-shot still running.
REQ-010 irq_clr  in  1  single-cycle strobe; clears irq.
REQ-011 cnt_clr  in  1  single-cycle strobe; clears event_cnt.
REQ-012 ena  out  1  detector enable.
REQ-013 vtrip  out  3  detector vtrip code.
REQ-014 otrip  out  3  detector otrip code.
REQ-015 force_short_oneshot  out  1  detector short one-shot control.
REQ-016 ready  out  1  high only in state ARMED.
REQ-017 bo_active  out  1  high only in state TRIPPED.
REQ-018 irq  out  1  sticky brownout event flag.
REQ-019 event_cnt  out  8  count of brownout events, saturating.

Function
REQ-020 bo_good SHALL pass through a 2-flop synchronizer, giving bo_good_s; the FSM SHALL use only bo_good_s.
REQ-021 States SHALL be OFF, SETTLE, ARMED and TRIPPED; all outputs SHALL be registered.
REQ-022 On any cfg_wr, vtrip, otrip and force_short_oneshot SHALL load cfg_vtrip, cfg_otrip and cfg_short on that edge, in every state.
REQ-023 Any state, cfg_wr with cfg_ena=0 -> OFF; ena=0 on the next edge.
REQ-024 Any state, cfg_wr with cfg_ena=1 -> SETTLE, settle counter loaded with SETTLE_CYC-1, ena=1 (covers restart within SETTLE).
REQ-025 SETTLE: counter SHALL decrement each cycle; at 0 without cfg_wr -> ARMED; ready=1 exactly SETTLE_CYC edges after the cfg_wr edge.
REQ-026 SETTLE: bo_good_s SHALL be ignored; no event, irq or count change.
REQ-027 ARMED with bo_good_s=0 -> TRIPPED; on the same edge event_cnt SHALL increment and irq SHALL set.
REQ-028 Latency: if bo_good falls before edge N, TRIPPED, irq and count update SHALL appear after edge N+2.
REQ-029 TRIPPED with bo_good_s=1 -> ARMED; only one event SHALL be counted per TRIPPED visit.
REQ-030 If cfg_wr and an ARMED->TRIPPED condition occur on the same edge, cfg_wr SHALL win and no event SHALL be counted.
REQ-031 event_cnt SHALL saturate at 255; cnt_clr SHALL zero it; cnt_clr together with an increment SHALL yield 1.
REQ-032 irq_clr SHALL zero irq; irq_clr together with a new event SHALL leave irq=1.
REQ-033 In OFF, ready, bo_active and ena SHALL be 0, while irq and event_cnt SHALL hold.

Reset
REQ-034 Reset SHALL force state OFF and outputs as follows: ena=0, vtrip=0, otrip=0, force_short_oneshot=0, ready=0, bo_active=0, irq=0, event_cnt=0.
REQ-035 Reset SHALL set synchronizer flops to 1 and the settle counter to 0.
REQ-036 Reset mid-operation SHALL take effect immediately, without a clock edge.
REQ-037 First cfg_wr after reset release SHALL be honoured on the first edge.

Verification
REQ-038 cfg_wr(ena=1, vtrip=5, otrip=2), SETTLE_CYC=64 -> ena=1, vtrip=5, otrip=2 next edge; ready=1 at edge 64; bo_good held 0 throughout settle -> irq=0, event_cnt=0.
REQ-039 ARMED, bo_good low 10 cycles then high -> irq=1 and event_cnt=1 at edge N+2; bo_active high until 3 edges after rise; ready returns.
REQ-040 260 brownout pulses -> event_cnt=255; cnt_clr and event on the same edge -> event_cnt=1.
REQ-041 irq_clr and a new event on the same edge -> irq=1; irq_clr alone -> irq=0 next edge.
REQ-042 cfg_wr(vtrip=3) at the same edge as a trip in ARMED -> SETTLE, no count; cfg_wr(cfg_ena=0) in TRIPPED -> OFF, ena=0, counts held.
REQ-043 rst asserted mid-SETTLE and mid-TRIPPED -> all outputs reach reset values immediately; no event after release while bo_good=1.
